// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that shares the common data bus (CDB)
// among NUM_REQ functional-unit result ports. Each port has a one-entry
// holding register, so a unit that loses arbitration can still hand off
// its result.
// Optional feature macro: CDB_ARB_REG_OUT_EN registers the CDB outputs and
// o_grant. Minimum accept-to-broadcast latency is then 2 cycles instead of 1.

// Per-port one-entry holding register.
module cdb_arb_hold #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic              i_release,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_v,
  output logic [TAG_W-1:0]  o_tag,
  output logic [DATA_W-1:0] o_data
);
  logic              v_q, v_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Flush beats a refill. A refill beats the release of the broadcast entry.
  always_comb begin
    v_d    = v_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (i_flush) begin
      v_d = 1'b0;
    end else if (i_load) begin
      v_d    = 1'b1;
      tag_d  = i_tag;
      data_d = i_data;
    end else if (i_release) begin
      v_d = 1'b0;
    end
  end

  // Holding-register state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_q    <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign o_v    = v_q;
  assign o_tag  = tag_q;
  assign o_data = data_q;
endmodule

module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  i_req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_cdb_valid,
  output logic [TAG_W-1:0]          o_cdb_tag,
  output logic [DATA_W-1:0]         o_cdb_data
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0][TAG_W-1:0]  hold_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0] hold_data;
  logic [NUM_REQ-1:0]             hold_v;
  logic [NUM_REQ-1:0]             ready;
  logic [NUM_REQ-1:0]             accept;
  logic [NUM_REQ-1:0]             win_grant;
  logic                           win_v;
  logic [IDX_W-1:0]               win_idx;
  logic [TAG_W-1:0]               win_tag;
  logic [DATA_W-1:0]              win_data;
  logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;

  assign req_tag  = i_req_tag;
  assign req_data = i_req_data;

  // Return (base + off) mod NUM_REQ. Here off < NUM_REQ, so at most one wrap is needed.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IDX_W-1:0];
  endfunction

  // Start the search at rr_ptr. The first occupied holding register wins.
  always_comb begin
    win_v     = 1'b0;
    win_idx   = '0;
    win_grant = '0;
    win_tag   = '0;
    win_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_v && hold_v[rr_idx(rr_ptr_q, i)]) begin
        win_v   = 1'b1;
        win_idx = rr_idx(rr_ptr_q, i);
      end
    end
    if (win_v) begin
      win_grant[win_idx] = 1'b1;
      win_tag            = hold_tag[win_idx];
      win_data           = hold_data[win_idx];
    end
  end

  // Ready is held low while reset or flush is asserted. A port whose entry is
  // being broadcast this cycle may be refilled in the same cycle.
  assign ready       = (i_rst_n && !i_flush) ? (~hold_v | win_grant) : '0;
  assign accept      = i_req_valid & ready;
  assign o_req_ready = ready;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_port
      cdb_arb_hold #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_hold (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_flush   (i_flush),
        .i_load    (accept[g]),
        .i_release (win_grant[g]),
        .i_tag     (req_tag[g]),
        .i_data    (req_data[g]),
        .o_v       (hold_v[g]),
        .o_tag     (hold_tag[g]),
        .o_data    (hold_data[g])
      );
    end
  endgenerate

  // After each broadcast, the port just past the winner gets top priority.
  // A flush resets the priority to port 0.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (i_flush)    rr_ptr_d = '0;
    else if (win_v) rr_ptr_d = rr_idx(win_idx, 1);
  end

  // Round-robin pointer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end

`ifdef CDB_ARB_REG_OUT_EN
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  // Register the arbitration decision. A flush drops the decision made in the
  // flush cycle, because its holding entry is discarded as well.
  always_comb begin
    cdb_valid_d = win_v;
    cdb_tag_d   = win_tag;
    cdb_data_d  = win_data;
    grant_d     = win_grant;
    if (i_flush) begin
      cdb_valid_d = 1'b0;
      cdb_tag_d   = '0;
      cdb_data_d  = '0;
      grant_d     = '0;
    end
  end

  // Registered broadcast stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      grant_q     <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      grant_q     <= grant_d;
    end
  end

  assign o_cdb_valid = cdb_valid_q;
  assign o_cdb_tag   = cdb_tag_q;
  assign o_cdb_data  = cdb_data_q;
  assign o_grant     = grant_q;
`else
  assign o_cdb_valid = win_v;
  assign o_cdb_tag   = win_tag;
  assign o_cdb_data  = win_data;
  assign o_grant     = win_grant;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter in its default build (combinational CDB outputs).
module tb_cdb_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst_n;
  logic                      flush;
  logic [NUM_REQ-1:0]        valid;
  logic [NUM_REQ*TAG_W-1:0]  tag;
  logic [NUM_REQ*DATA_W-1:0] data;
  logic [NUM_REQ-1:0]        ready;
  logic [NUM_REQ-1:0]        grant;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .i_req_valid (valid),
    .i_req_tag   (tag),
    .i_req_data  (data),
    .o_req_ready (ready),
    .o_grant     (grant),
    .o_cdb_valid (cdb_valid),
    .o_cdb_tag   (cdb_tag),
    .o_cdb_data  (cdb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int k, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    tag[k*TAG_W +: TAG_W]    = t;
    data[k*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; valid = '0; tag = '0; data = '0;
    for (int k = 0; k < NUM_REQ; k++) set_port(k, TAG_W'(k + 1), 32'hA000_0000 + 32'(k));

    // Reset asserted with every port valid.
    #1 rst_n = 1'b0; valid = 4'hF;
    #1;
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_tag", 64'(cdb_tag), 64'h0);
    chk("rst_data", 64'(cdb_data), 64'h0);
    tick();
    chk("rst_ready_edge", 64'(ready), 64'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(ready), 64'hF);
    chk("post_rst_cdb_valid", 64'(cdb_valid), 64'h0);

    // All four ports are accepted on one edge, then drain in round-robin order.
    tick(); valid = '0;
    chk("all_g0", 64'(grant), 64'h1);
    chk("all_t0", 64'(cdb_tag), 64'h1);
    chk("all_d0", 64'(cdb_data), 64'hA000_0000);
    chk("all_r0", 64'(ready), 64'h1);
    tick();
    chk("all_g1", 64'(grant), 64'h2);
    chk("all_t1", 64'(cdb_tag), 64'h2);
    chk("all_r1", 64'(ready), 64'h3);
    tick();
    chk("all_g2", 64'(grant), 64'h4);
    chk("all_r2", 64'(ready), 64'h7);
    tick();
    chk("all_g3", 64'(grant), 64'h8);
    chk("all_d3", 64'(cdb_data), 64'hA000_0003);
    chk("all_r3", 64'(ready), 64'hF);
    tick();
    chk("all_done_v", 64'(cdb_valid), 64'h0);
    chk("all_done_g", 64'(grant), 64'h0);
    chk("all_done_tag", 64'(cdb_tag), 64'h0);
    chk("all_done_data", 64'(cdb_data), 64'h0);

    // Single request on port 2.
    set_port(2, 6'h15, 32'hDEADBEEF);
    valid = 4'b0100;
    tick(); valid = '0;
    chk("one_v", 64'(cdb_valid), 64'h1);
    chk("one_g", 64'(grant), 64'h4);
    chk("one_tag", 64'(cdb_tag), 64'h15);
    chk("one_data", 64'(cdb_data), 64'hDEADBEEF);
    tick();
    chk("one_done", 64'(cdb_valid), 64'h0);

    // The pointer is now 3, so port 3 wins over port 0.
    valid = 4'b1001;
    tick(); valid = '0;
    chk("rr3_first", 64'(grant), 64'h8);
    tick();
    chk("rr3_second", 64'(grant), 64'h1);
    tick();
    chk("rr3_done", 64'(cdb_valid), 64'h0);

    // Ports 0 and 3 stream continuously and alternate (pointer starts at 1).
    valid = 4'b1001;
    tick(); chk("str_g0", 64'(grant), 64'h8);
    tick(); chk("str_g1", 64'(grant), 64'h1);
    chk("str_t1", 64'(cdb_tag), 64'h1);
    tick(); chk("str_g2", 64'(grant), 64'h8);
    tick(); chk("str_g3", 64'(grant), 64'h1);
    valid = '0;
    tick(); chk("str_g4", 64'(grant), 64'h8);
    tick(); chk("str_done", 64'(cdb_valid), 64'h0);

    // Flush while ports 0, 2 and 3 are held and port 1 requests.
    valid = 4'b1101;
    tick();
    valid = 4'b0010; flush = 1'b1;
    #1;
    chk("fl_ready", 64'(ready), 64'h0);
    chk("fl_bcast_v", 64'(cdb_valid), 64'h1);
    chk("fl_bcast_g", 64'(grant), 64'h1);
    tick();
    flush = 1'b0; valid = '0;
    #1;
    chk("fl_after_v", 64'(cdb_valid), 64'h0);
    chk("fl_after_g", 64'(grant), 64'h0);
    chk("fl_after_r", 64'(ready), 64'hF);
    // The flush reset the pointer to 0, so port 0 wins over port 3.
    valid = 4'b1001;
    tick(); valid = '0;
    chk("fl_rr_first", 64'(grant), 64'h1);
    tick();
    chk("fl_rr_second", 64'(grant), 64'h8);
    tick();
    chk("fl_rr_done", 64'(cdb_valid), 64'h0);

    // Asynchronous reset while a result is on the bus.
    set_port(1, 6'h2A, 32'h1234_5678);
    valid = 4'b0010;
    tick(); valid = '0;
    chk("mr_v", 64'(cdb_valid), 64'h1);
    chk("mr_tag", 64'(cdb_tag), 64'h2A);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rst_v", 64'(cdb_valid), 64'h0);
    chk("mr_rst_g", 64'(grant), 64'h0);
    chk("mr_rst_tag", 64'(cdb_tag), 64'h0);
    chk("mr_rst_data", 64'(cdb_data), 64'h0);
    chk("mr_rst_ready", 64'(ready), 64'h0);
    #3 rst_n = 1'b1;
    tick();
    chk("mr_lost", 64'(cdb_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
